// File: rtl/dlfloat_dot_engine_if.sv
// Operand / result stream bundle for dlfloat_dot_engine.
//   op_data   16-bit DLFloat16 operand from the source
//   op_valid  operand present
//   op_ready  engine accepts the operand when op_valid is also high
//   res_byte  serialised result byte (high byte first, then low byte)
//   res_valid res_byte is valid
//   res_ready sink takes the byte
// The master modport is the operand source / result sink side;
// the slave modport is the engine side.
interface dlfloat_dot_engine_if;
  logic [15:0] op_data;
  logic        op_valid;
  logic        op_ready;
  logic [7:0]  res_byte;
  logic        res_valid;
  logic        res_ready;

  modport master (
    output op_data, op_valid, res_ready,
    input  op_ready, res_byte, res_valid
  );

  modport slave (
    input  op_data, op_valid, res_ready,
    output op_ready, res_byte, res_valid
  );
endinterface

// File: rtl/dlfloat_dot_engine.sv
// DLFloat16 dot-product engine. Consumes VEC_LEN (a,b) operand pairs,
// multiplies each pair and accumulates the products, then sends the
// 16-bit accumulator as two bytes, high byte first.
//   clk, rst   clock and asynchronous active-high reset
//   start      begin one vector (sampled in IDLE only)
//   acc_clear  zero the accumulator (sampled in IDLE only)
//   bus        operand / result streams (slave side)
//   busy       engine is not in IDLE
//   nan_flag   accumulator holds the NaN pattern 0xFFFF
// DLFloat16: sign [15], exponent [14:9] bias 31, mantissa [8:0] with a
// hidden 1; 0x0000 is zero and 0xFFFF is NaN.
module dlfloat_dot_engine #(
  parameter int VEC_LEN  = 4,
  parameter int ACC_MODE = 0
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic                        acc_clear,
  dlfloat_dot_engine_if.slave         bus,
  output logic                        busy,
  output logic                        nan_flag
);

  localparam int CW = $clog2(VEC_LEN + 1);
  localparam logic [CW-1:0] LAST = CW'(VEC_LEN);

  typedef enum logic [2:0] {IDLE, GET_A, GET_B, MUL, ACC, SEND_HI, SEND_LO} state_t;

  state_t        state;
  logic [15:0]   a, b, p, acc;
  logic [CW-1:0] cnt;

  logic [15:0] prod;
  logic [19:0] mp;
  logic [5:0]  pe;

  logic [15:0] sum;
  logic        x_big, s_big, s_sm;
  logic [5:0]  e_big, e_sm, e_res;
  logic [9:0]  m_big, m_sm, m_shift, diff, norm;
  logic [10:0] raw;
  logic [8:0]  m_res;
  logic [3:0]  lz;

  logic unused_bits;
  assign unused_bits = ^{mp[8:0], norm[9]};

  // Product of the latched operands; the 10x10 mantissa product is
  // truncated, and a product >= 2.0 bumps the exponent by one.
  always_comb begin
    mp   = 20'({1'b1, a[8:0]}) * 20'({1'b1, b[8:0]});
    pe   = a[14:9] + b[14:9] - 6'd31;
    prod = 16'h0000;
    if (a == 16'hFFFF || b == 16'hFFFF)
      prod = 16'hFFFF;
    else if (a == 16'h0000 || b == 16'h0000)
      prod = 16'h0000;
    else if (mp[19])
      prod = {a[15] ^ b[15], pe + 6'd1, mp[18:10]};
    else
      prod = {a[15] ^ b[15], pe, mp[17:9]};
  end

  // Accumulator plus product. An exponent of 0 marks a zero operand that
  // contributes nothing. The smaller operand is aligned by a truncating
  // right shift; a full cancellation, or a left shift that would drive
  // the exponent to 0 or below, yields 0x0000.
  always_comb begin
    x_big   = 1'b0;
    s_big   = 1'b0;
    s_sm    = 1'b0;
    e_big   = '0;
    e_sm    = '0;
    e_res   = '0;
    m_big   = '0;
    m_sm    = '0;
    m_shift = '0;
    diff    = '0;
    norm    = '0;
    raw     = '0;
    m_res   = '0;
    lz      = '0;
    sum     = 16'h0000;
    if (acc == 16'hFFFF || p == 16'hFFFF) begin
      sum = 16'hFFFF;
    end else if (acc[14:9] == 6'd0 && p[14:9] == 6'd0) begin
      sum = 16'h0000;
    end else if (acc[14:9] == 6'd0) begin
      sum = p;
    end else if (p[14:9] == 6'd0) begin
      sum = acc;
    end else begin
      x_big = (acc[14:9] > p[14:9]) || (acc[14:9] == p[14:9] && acc[8:0] >= p[8:0]);
      if (x_big) begin
        e_big = acc[14:9]; m_big = {1'b1, acc[8:0]}; s_big = acc[15];
        e_sm  = p[14:9];   m_sm  = {1'b1, p[8:0]};   s_sm  = p[15];
      end else begin
        e_big = p[14:9];   m_big = {1'b1, p[8:0]};   s_big = p[15];
        e_sm  = acc[14:9]; m_sm  = {1'b1, acc[8:0]}; s_sm  = acc[15];
      end
      m_shift = m_sm >> (e_big - e_sm);
      if (s_big == s_sm) begin
        raw = {1'b0, m_big} + {1'b0, m_shift};
        if (raw[10]) begin
          m_res = raw[9:1];
          e_res = e_big + 6'd1;
        end else begin
          m_res = raw[8:0];
          e_res = e_big;
        end
        sum = {s_big, e_res, m_res};
      end else begin
        diff = m_big - m_shift;
        for (int i = 0; i < 10; i++)
          if (diff[i]) lz = 4'(9 - i);
        if (diff == 10'd0 || {2'b00, lz} >= e_big) begin
          sum = 16'h0000;
        end else begin
          norm = diff << lz;
          sum  = {s_big, e_big - {2'b00, lz}, norm[8:0]};
        end
      end
    end
  end

  // Control FSM with registered handshake and status outputs.
  // In ACC the result byte is loaded from the fresh sum so that it is
  // valid in the same cycle the FSM enters SEND_HI.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      a             <= '0;
      b             <= '0;
      p             <= '0;
      acc           <= '0;
      cnt           <= '0;
      bus.op_ready  <= 1'b0;
      bus.res_valid <= 1'b0;
      bus.res_byte  <= 8'h00;
      busy          <= 1'b0;
      nan_flag      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (acc_clear || (start && ACC_MODE == 0)) begin
            acc      <= 16'h0000;
            nan_flag <= 1'b0;
          end
          if (start) begin
            state        <= GET_A;
            cnt          <= '0;
            bus.op_ready <= 1'b1;
            busy         <= 1'b1;
          end
        end
        GET_A: begin
          if (bus.op_valid) begin
            a     <= bus.op_data;
            state <= GET_B;
          end
        end
        GET_B: begin
          if (bus.op_valid) begin
            b            <= bus.op_data;
            state        <= MUL;
            bus.op_ready <= 1'b0;
          end
        end
        MUL: begin
          p     <= prod;
          state <= ACC;
        end
        ACC: begin
          acc      <= sum;
          nan_flag <= (sum == 16'hFFFF);
          cnt      <= cnt + CW'(1);
          if (cnt + CW'(1) == LAST) begin
            state         <= SEND_HI;
            bus.res_valid <= 1'b1;
            bus.res_byte  <= sum[15:8];
          end else begin
            state        <= GET_A;
            bus.op_ready <= 1'b1;
          end
        end
        SEND_HI: begin
          if (bus.res_ready) begin
            state        <= SEND_LO;
            bus.res_byte <= acc[7:0];
          end
        end
        SEND_LO: begin
          if (bus.res_ready) begin
            state         <= IDLE;
            bus.res_valid <= 1'b0;
            bus.res_byte  <= 8'h00;
            busy          <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dlfloat_dot_engine.sv
// Directed self-checking bench for dlfloat_dot_engine. Two instances share
// clock, reset and operand/ready inputs: dut2 (VEC_LEN=2, ACC_MODE=0) and
// dut1 (VEC_LEN=1, ACC_MODE=1). Only the selected instance is started, so
// the other stays in IDLE and ignores the shared operand stream.
module tb_dlfloat_dot_engine;

  logic        clk = 1'b0;
  logic        rst;
  logic        start1, start2, clr1, clr2;
  logic [15:0] op_data;
  logic        op_valid, res_ready;
  logic        busy1, busy2, nan1, nan2;
  int          sel;

  logic        cur_op_ready, cur_res_valid, cur_busy;
  logic [7:0]  cur_res_byte;

  int errors = 0;
  int checks = 0;

  dlfloat_dot_engine_if bus1();
  dlfloat_dot_engine_if bus2();

  assign bus1.op_data   = op_data;
  assign bus1.op_valid  = op_valid;
  assign bus1.res_ready = res_ready;
  assign bus2.op_data   = op_data;
  assign bus2.op_valid  = op_valid;
  assign bus2.res_ready = res_ready;

  dlfloat_dot_engine #(.VEC_LEN(2), .ACC_MODE(0)) dut2 (
    .clk(clk), .rst(rst), .start(start2), .acc_clear(clr2),
    .bus(bus2.slave), .busy(busy2), .nan_flag(nan2)
  );

  dlfloat_dot_engine #(.VEC_LEN(1), .ACC_MODE(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .acc_clear(clr1),
    .bus(bus1.slave), .busy(busy1), .nan_flag(nan1)
  );

  assign cur_op_ready  = (sel == 1) ? bus1.op_ready  : bus2.op_ready;
  assign cur_res_valid = (sel == 1) ? bus1.res_valid : bus2.res_valid;
  assign cur_res_byte  = (sel == 1) ? bus1.res_byte  : bus2.res_byte;
  assign cur_busy      = (sel == 1) ? busy1          : busy2;

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%04h expected 0x%04h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Runs one vector on the selected instance and checks the two result
  // bytes against exp. stall holds res_ready low that many cycles in
  // SEND_HI; toggle drives op_valid 1/0 on alternate cycles.
  task automatic applyStimulus(input int which, input logic [15:0] o0, input logic [15:0] o1,
                               input logic [15:0] o2, input logic [15:0] o3, input int n,
                               input int stall, input bit toggle, input bit clr,
                               input string tag, input logic [15:0] exp, output int latency);
    logic [15:0] ops [4];
    int idx;
    bit phase;
    bit hs;
    ops = '{o0, o1, o2, o3};
    sel = which;
    res_ready = (stall == 0);
    if (which == 1) begin start1 = 1'b1; clr1 = clr; end
    else            begin start2 = 1'b1; clr2 = clr; end
    step();
    start1 = 1'b0; start2 = 1'b0; clr1 = 1'b0; clr2 = 1'b0;
    latency = 1;
    idx = 0;
    phase = 1'b1;
    while (!cur_res_valid && latency < 300) begin
      op_data  = (idx < n) ? ops[idx] : 16'h0000;
      op_valid = (idx < n) && (!toggle || phase);
      hs = op_valid && cur_op_ready;
      step();
      latency++;
      if (hs) idx++;
      phase = ~phase;
    end
    op_valid = 1'b0;
    if (!cur_res_valid) begin
      checkOutput({tag, " timeout"}, 16'd0, 16'd1);
      res_ready = 1'b1;
      return;
    end
    checkOutput({tag, " ops consumed"}, 16'(idx), 16'(n));
    for (int s = 0; s < stall; s++) begin
      checkOutput({tag, " stall hold"}, {7'd0, cur_res_valid, cur_res_byte}, {8'h01, exp[15:8]});
      step();
    end
    res_ready = 1'b1;
    checkOutput({tag, " hi byte"}, {7'd0, cur_res_valid, cur_res_byte}, {8'h01, exp[15:8]});
    step();
    checkOutput({tag, " lo byte"}, {7'd0, cur_res_valid, cur_res_byte}, {8'h01, exp[7:0]});
    step();
    checkOutput({tag, " idle after"}, {6'd0, cur_busy, cur_res_valid, cur_res_byte}, 16'h0000);
  endtask

  initial begin : main
    int lat;
    int seen;
    rst = 1'b1;
    start1 = 1'b0; start2 = 1'b0; clr1 = 1'b0; clr2 = 1'b0;
    op_data = 16'h0000; op_valid = 1'b0; res_ready = 1'b1; sel = 2;
    step();
    step();
    checkOutput("reset dut2 outputs", {11'd0, busy2, nan2, bus2.op_ready, bus2.res_valid, |bus2.res_byte}, 16'h0000);
    checkOutput("reset dut1 outputs", {11'd0, busy1, nan1, bus1.op_ready, bus1.res_valid, |bus1.res_byte}, 16'h0000);
    rst = 1'b0;
    step();

    applyStimulus(2, 16'h3E00, 16'h3E00, 16'h3E00, 16'h3E00, 4, 0, 1'b0, 1'b0, "1+1", 16'h4000, lat);
    checkOutput("latency", 16'(lat), 16'd9);
    applyStimulus(2, 16'h3E00, 16'h3E00, 16'h3E00, 16'h3E00, 4, 5, 1'b0, 1'b0, "stall", 16'h4000, lat);
    applyStimulus(2, 16'h0000, 16'h3E00, 16'h3E00, 16'h3E00, 4, 0, 1'b0, 1'b0, "zero op", 16'h3E00, lat);
    applyStimulus(2, 16'hFFFF, 16'h3E00, 16'h3E00, 16'h3E00, 4, 0, 1'b0, 1'b0, "nan op", 16'hFFFF, lat);
    checkOutput("nan flag set", {15'd0, nan2}, 16'd1);
    applyStimulus(2, 16'h3F00, 16'h3F00, 16'hBE00, 16'h3E00, 4, 0, 1'b0, 1'b0, "2.25-1", 16'h3E80, lat);
    checkOutput("nan flag cleared", {15'd0, nan2}, 16'd0);
    applyStimulus(2, 16'h3E00, 16'h3E00, 16'hBE00, 16'h3F00, 4, 0, 1'b0, 1'b0, "1-1.5", 16'hBC00, lat);
    applyStimulus(2, 16'h3E00, 16'h3E00, 16'hBE00, 16'h3E00, 4, 0, 1'b0, 1'b0, "cancel", 16'h0000, lat);
    applyStimulus(2, 16'h3E00, 16'h3E00, 16'h3E00, 16'h3E00, 4, 0, 1'b1, 1'b0, "toggle", 16'h4000, lat);

    applyStimulus(1, 16'h3E00, 16'h3E00, 16'h0, 16'h0, 2, 0, 1'b0, 1'b0, "accum first", 16'h3E00, lat);
    applyStimulus(1, 16'h3E00, 16'h3E00, 16'h0, 16'h0, 2, 0, 1'b0, 1'b0, "accum second", 16'h4000, lat);
    clr1 = 1'b1;
    step();
    clr1 = 1'b0;
    applyStimulus(1, 16'h3E00, 16'h3E00, 16'h0, 16'h0, 2, 0, 1'b0, 1'b0, "after clear", 16'h3E00, lat);
    applyStimulus(1, 16'h3E00, 16'h3E00, 16'h0, 16'h0, 2, 0, 1'b0, 1'b1, "start+clear", 16'h3E00, lat);

    sel = 1;
    start1 = 1'b1;
    step();
    start1 = 1'b0;
    op_data = 16'h3E00;
    op_valid = 1'b1;
    step();
    op_valid = 1'b0;
    step();
    #2 rst = 1'b1;
    #2 rst = 1'b0;
    checkOutput("mid reset outputs", {11'd0, busy1, nan1, bus1.op_ready, bus1.res_valid, |bus1.res_byte}, 16'h0000);
    seen = 0;
    op_valid = 1'b1;
    for (int c = 0; c < 10; c++) begin
      step();
      if (bus1.res_valid || busy1) seen++;
    end
    op_valid = 1'b0;
    checkOutput("no stale result", 16'(seen), 16'd0);
    applyStimulus(1, 16'h3E00, 16'h3E00, 16'h0, 16'h0, 2, 0, 1'b0, 1'b0, "post reset", 16'h3E00, lat);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
